// File: rtl/dmem_bist_pkg.sv
// Shared types and helpers for the data-memory march BIST.
package dmem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_PAT,
    R_PAT,
    W_INV,
    R_INV,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_SEED = 32'hA5A5_0000;

  // Background pattern for a word; the address term makes every word unique.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/dmem_bist_if.sv
// Data-memory port as seen by the BIST: address/write strobe/write data out, combinational read data back.
interface dmem_bist_if;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport master (
    output mem_addr,
    output mem_write_en,
    output mem_w_data,
    input  mem_r_data
  );

  modport slave (
    input  mem_addr,
    input  mem_write_en,
    input  mem_w_data,
    output mem_r_data
  );
endinterface

// File: rtl/dmem_bist_addr_gen.sv
// Word address counter for the march: synchronous load, clamped up/down count, end-of-range flags.
module dmem_bist_addr_gen #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [AW-1:0] i_loadVal,
  input  logic          i_up,
  input  logic          i_down,
  output logic [AW-1:0] o_addr,
  output logic          o_first,
  output logic          o_last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0] r_addr;

  // Counting is clamped at both ends so the address can never leave 0..DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_loadVal;
    end else if (i_up && !o_last) begin
      r_addr <= r_addr + 1'b1;
    end else if (i_down && !o_first) begin
      r_addr <= r_addr - 1'b1;
    end
  end

  assign o_addr  = r_addr;
  assign o_first = (r_addr == '0);
  assign o_last  = (r_addr == LAST_ADDR);

endmodule

// File: rtl/dmem_bist.sv
// March BIST for the data memory: ascending write, read/invert, descending read; reports first failure.
module dmem_bist
  import dmem_bist_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter logic [31:0] SEED  = DEFAULT_SEED,
  parameter int          ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_errCount,
  output logic [31:0]      o_failAddr,
  output logic [31:0]      o_failData,
  dmem_bist_if.master      memBus
);

  localparam int AW = $clog2(DEPTH);

  state_t           r_state;
  logic [ERR_W-1:0] r_errCount;
  logic [31:0]      r_failAddr;
  logic [31:0]      r_failData;

  logic [AW-1:0] w_addr;
  logic          w_first;
  logic          w_last;
  logic          w_load;
  logic          w_up;
  logic          w_down;
  logic [31:0]   w_addr32;
  logic [31:0]   w_pat;
  logic [31:0]   w_expected;
  logic          w_isRead;
  logic          w_mismatch;

  dmem_bist_addr_gen #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_addrGen (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_loadVal('0),
    .i_up     (w_up),
    .i_down   (w_down),
    .o_addr   (w_addr),
    .o_first  (w_first),
    .o_last   (w_last)
  );

  // W_INV at the top word keeps its address so the descending pass starts at DEPTH-1.
  always_comb begin
    w_load = 1'b0;
    w_up   = 1'b0;
    w_down = 1'b0;
    unique case (r_state)
      IDLE, DONE: w_load = i_start;
      W_PAT: begin
        w_up   = !w_last;
        w_load = w_last;
      end
      W_INV:   w_up   = !w_last;
      R_INV:   w_down = 1'b1;
      default: ;
    endcase
  end

  assign w_addr32   = {{(32 - AW){1'b0}}, w_addr};
  assign w_pat      = pat(SEED, w_addr32);
  assign w_expected = (r_state == R_INV) ? ~w_pat : w_pat;
  assign w_isRead   = (r_state == R_PAT) || (r_state == R_INV);
  assign w_mismatch = w_isRead && (memBus.mem_r_data != w_expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_errCount <= '0;
      r_failAddr <= '0;
      r_failData <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state    <= W_PAT;
            r_errCount <= '0;
            r_failAddr <= '0;
            r_failData <= '0;
          end
        end
        W_PAT:   if (w_last) r_state <= R_PAT;
        R_PAT:   r_state <= W_INV;
        W_INV:   r_state <= w_last ? R_INV : R_PAT;
        R_INV:   if (w_first) r_state <= DONE;
        default: r_state <= IDLE;
      endcase

      // Only the first miss is captured; the counter sticks at all-ones.
      if (w_mismatch) begin
        if (r_errCount == '0) begin
          r_failAddr <= w_addr32;
          r_failData <= memBus.mem_r_data;
        end
        if (r_errCount != '1) begin
          r_errCount <= r_errCount + 1'b1;
        end
      end
    end
  end

  assign o_busy     = (r_state == W_PAT) || (r_state == R_PAT) ||
                      (r_state == W_INV) || (r_state == R_INV);
  assign o_done     = (r_state == DONE);
  assign o_pass     = o_done && (r_errCount == '0);
  assign o_errCount = r_errCount;
  assign o_failAddr = r_failAddr;
  assign o_failData = r_failData;

  assign memBus.mem_write_en = (r_state == W_PAT) || (r_state == W_INV);
  assign memBus.mem_addr     = o_busy ? w_addr32 : 32'd0;
  assign memBus.mem_w_data   = (r_state == W_PAT) ? w_pat :
                               (r_state == W_INV) ? ~w_pat : 32'd0;

endmodule
